// File: rtl/checkpoint_restore_unit.sv
// Shadow checkpoint of CPU architectural state (regfile + next PC), restored on request.
// Optional build macro RECOVERY_PARITY_EN adds even parity per shadow entry and a sticky restore_error.
module checkpoint_restore_unit #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            freeze_cpu,
  input  logic            recover_cpu,
  input  logic            resume_cpu,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            commit_rd_we,
  input  logic [AW-1:0]   commit_rd,
  input  logic [XLEN-1:0] commit_rd_data,
  output logic            rf_wr_en,
  output logic [AW-1:0]   rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  input  logic            rf_wr_ready,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_load_val,
  output logic            recovery_done,
  output logic            restore_busy,
  output logic            restore_error
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESTORE_RF = 2'd1,
    RESTORE_PC = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic            rf_wr_en_q;
  logic [AW-1:0]   rf_wr_addr_q;
  logic [XLEN-1:0] rf_wr_data_q;
  logic            pc_load_q;
  logic [XLEN-1:0] pc_load_val_q;
  logic            recovery_done_q;
  logic            restore_error_q;

  logic [XLEN-1:0] shadow_q [NREGS];
  logic [XLEN-1:0] shadow_d [NREGS];
  logic [XLEN-1:0] ckpt_pc_q;
  logic [XLEN-1:0] ckpt_pc_d;

`ifdef RECOVERY_PARITY_EN
  logic            shadow_par_q [NREGS];
  logic            shadow_par_d [NREGS];
  logic            ckpt_pc_par_q;
  logic            ckpt_pc_par_d;
`endif

  logic            capture;
  logic [AW-1:0]   next_idx;
  logic            next_ok;
  logic            pc_ok;
  logic            advance;
  logic            last_idx;

  assign capture = commit_valid && !freeze_cpu && !recover_cpu;

  // Restore never overlaps capture (recover_cpu blocks it), so the image stays frozen while replayed.
  always_comb begin
    shadow_d  = shadow_q;
    ckpt_pc_d = ckpt_pc_q;
`ifdef RECOVERY_PARITY_EN
    shadow_par_d  = shadow_par_q;
    ckpt_pc_par_d = ckpt_pc_par_q;
`endif
    if (capture) begin
      ckpt_pc_d = commit_pc + XLEN'(4);
`ifdef RECOVERY_PARITY_EN
      ckpt_pc_par_d = ^ckpt_pc_d;
`endif
      if (commit_rd_we && (commit_rd != '0)) begin
        shadow_d[commit_rd] = commit_rd_data;
`ifdef RECOVERY_PARITY_EN
        shadow_par_d[commit_rd] = ^commit_rd_data;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_q[i] <= '0;
`ifdef RECOVERY_PARITY_EN
        shadow_par_q[i] <= 1'b0;
`endif
      end
      ckpt_pc_q <= RESET_PC;
`ifdef RECOVERY_PARITY_EN
      ckpt_pc_par_q <= ^RESET_PC;
`endif
    end else begin
      shadow_q  <= shadow_d;
      ckpt_pc_q <= ckpt_pc_d;
`ifdef RECOVERY_PARITY_EN
      shadow_par_q  <= shadow_par_d;
      ckpt_pc_par_q <= ckpt_pc_par_d;
`endif
    end
  end

  always_comb begin
    next_idx = (state_q == IDLE) ? AW'(1) : idx_q + AW'(1);
`ifdef RECOVERY_PARITY_EN
    next_ok  = ~^{shadow_q[next_idx], shadow_par_q[next_idx]};
    pc_ok    = ~^{ckpt_pc_q, ckpt_pc_par_q};
`else
    next_ok  = 1'b1;
    pc_ok    = 1'b1;
`endif
    // A skipped (bad parity) entry has no write pending, so it moves on after one cycle.
    advance  = rf_wr_ready || !rf_wr_en_q;
    last_idx = (idx_q == AW'(NREGS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      rf_wr_en_q      <= 1'b0;
      rf_wr_addr_q    <= '0;
      rf_wr_data_q    <= '0;
      pc_load_q       <= 1'b0;
      pc_load_val_q   <= '0;
      recovery_done_q <= 1'b0;
      restore_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (recover_cpu) begin
            state_q      <= RESTORE_RF;
            idx_q        <= next_idx;
            rf_wr_addr_q <= next_idx;
            rf_wr_data_q <= shadow_q[next_idx];
            rf_wr_en_q   <= next_ok;
            if (!next_ok) restore_error_q <= 1'b1;
          end
        end
        RESTORE_RF: begin
          if (!recover_cpu) begin
            state_q      <= IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
          end else if (advance) begin
            if (last_idx) begin
              state_q       <= RESTORE_PC;
              rf_wr_en_q    <= 1'b0;
              rf_wr_addr_q  <= '0;
              rf_wr_data_q  <= '0;
              pc_load_q     <= 1'b1;
              pc_load_val_q <= ckpt_pc_q;
              if (!pc_ok) restore_error_q <= 1'b1;
            end else begin
              idx_q        <= next_idx;
              rf_wr_addr_q <= next_idx;
              rf_wr_data_q <= shadow_q[next_idx];
              rf_wr_en_q   <= next_ok;
              if (!next_ok) restore_error_q <= 1'b1;
            end
          end
        end
        RESTORE_PC: begin
          pc_load_q     <= 1'b0;
          pc_load_val_q <= '0;
          if (!recover_cpu) begin
            state_q <= IDLE;
          end else begin
            state_q         <= DONE;
            recovery_done_q <= 1'b1;
          end
        end
        DONE: begin
          if (!recover_cpu || resume_cpu) begin
            state_q         <= IDLE;
            recovery_done_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rf_wr_en      = rf_wr_en_q;
  assign rf_wr_addr    = rf_wr_addr_q;
  assign rf_wr_data    = rf_wr_data_q;
  assign pc_load       = pc_load_q;
  assign pc_load_val   = pc_load_val_q;
  assign recovery_done = recovery_done_q;
  assign restore_busy  = (state_q == RESTORE_RF) || (state_q == RESTORE_PC);
  assign restore_error = restore_error_q;

endmodule

// File: tb/tb_checkpoint_restore_unit.sv
// Directed self-checking bench for checkpoint_restore_unit (default build).
module tb_checkpoint_restore_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze_cpu, recover_cpu, resume_cpu;
  logic        commit_valid, commit_rd_we;
  logic [31:0] commit_pc, commit_rd_data;
  logic [4:0]  commit_rd;
  logic        rf_wr_en, rf_wr_ready, pc_load, recovery_done, restore_busy, restore_error;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data, pc_load_val;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_rf [32];
  logic [31:0] exp_pc;
  logic [31:0] got_rf [32];
  logic [31:0] got_pc;
  int wr_cnt, order_err, hold_err, x0_hits, pc_cnt, pc_cycle, done_cycle, first_addr, busy_first;
  logic done_after, busy_after;

  checkpoint_restore_unit dut (
    .clk(clk), .reset(reset), .freeze_cpu(freeze_cpu), .recover_cpu(recover_cpu),
    .resume_cpu(resume_cpu), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_rd_we(commit_rd_we), .commit_rd(commit_rd), .commit_rd_data(commit_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_ready(rf_wr_ready), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .recovery_done(recovery_done), .restore_busy(restore_busy), .restore_error(restore_error)
  );

  always #5 clk = ~clk;

  task automatic do_commit(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                           input logic [31:0] data);
    @(negedge clk);
    commit_valid = 1'b1; commit_pc = pc; commit_rd_we = we; commit_rd = rd; commit_rd_data = data;
    @(negedge clk);
    commit_valid = 1'b0; commit_rd_we = 1'b0;
  endtask

  // Drives one recovery request and records what the DUT wrote, per cycle after the first sampling edge.
  task automatic run_restore(input int stall_at, input int stall_n, input int abort_at,
                             input bit use_resume);
    int cyc, stall_left, exp_addr, post;
    bit prev_stalled;
    wr_cnt = 0; order_err = 0; hold_err = 0; x0_hits = 0; pc_cnt = 0; pc_cycle = -1;
    done_cycle = -1; first_addr = -1; busy_first = -1; got_pc = 32'hxxxx_xxxx;
    for (int i = 0; i < 32; i++) got_rf[i] = 32'hxxxx_xxxx;
    stall_left = stall_n; exp_addr = 1; post = -1; prev_stalled = 1'b0;
    @(negedge clk);
    recover_cpu = 1'b1;
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) busy_first = int'(restore_busy);
      if (pc_load) begin pc_cnt++; pc_cycle = cyc; got_pc = pc_load_val; end
      if (recovery_done) begin done_cycle = cyc; break; end
      if (post >= 0) begin post++; if (post >= 6) break; end
      rf_wr_ready = 1'b1;
      if (rf_wr_en) begin
        if (rf_wr_addr == 5'd0) x0_hits++;
        if (prev_stalled && int'(rf_wr_addr) != stall_at) hold_err++;
        prev_stalled = 1'b0;
        if (post < 0 && abort_at > 0 && int'(rf_wr_addr) == abort_at) begin
          recover_cpu = 1'b0; post = 0;
        end
        if (int'(rf_wr_addr) == stall_at && stall_left > 0) begin
          rf_wr_ready = 1'b0; stall_left--; prev_stalled = 1'b1;
        end
        if (rf_wr_ready) begin
          if (first_addr < 0) first_addr = int'(rf_wr_addr);
          if (int'(rf_wr_addr) != exp_addr) order_err++;
          exp_addr = int'(rf_wr_addr) + 1;
          got_rf[rf_wr_addr] = rf_wr_data;
          wr_cnt++;
        end
      end
    end
    rf_wr_ready = 1'b1;
    if (done_cycle >= 0) begin
      if (use_resume) begin
        resume_cpu = 1'b1;
        @(posedge clk); #1;
        done_after = recovery_done;
        recover_cpu = 1'b0; resume_cpu = 1'b0;
      end else begin
        recover_cpu = 1'b0;
        @(posedge clk); #1;
        done_after = recovery_done;
      end
    end else begin
      recover_cpu = 1'b0;
      done_after = recovery_done;
    end
    busy_after = restore_busy;
    @(posedge clk); #1;
  endtask

  task automatic check_full_restore(input string tag, input int extra);
    n_cmp++;
    if (wr_cnt !== 31) begin n_bad++; $display("[TB] FAIL %s wr_cnt: got %0d expected 31", tag, wr_cnt); end
    n_cmp++;
    if (order_err !== 0 || x0_hits !== 0) begin
      n_bad++; $display("[TB] FAIL %s order/x0: got order_err=%0d x0_hits=%0d expected 0/0", tag, order_err, x0_hits);
    end
    for (int i = 1; i < 32; i++) begin
      n_cmp++;
      if (got_rf[i] !== exp_rf[i]) begin
        n_bad++; $display("[TB] FAIL %s x%0d data: got %h expected %h", tag, i, got_rf[i], exp_rf[i]);
      end
    end
    n_cmp++;
    if (pc_cnt !== 1 || got_pc !== exp_pc) begin
      n_bad++; $display("[TB] FAIL %s pc_load: got cnt=%0d val=%h expected cnt=1 val=%h", tag, pc_cnt, got_pc, exp_pc);
    end
    n_cmp++;
    if (pc_cycle !== 32 + extra) begin n_bad++; $display("[TB] FAIL %s pc_cycle: got %0d expected %0d", tag, pc_cycle, 32 + extra); end
    n_cmp++;
    if (done_cycle !== 33 + extra) begin n_bad++; $display("[TB] FAIL %s done_cycle: got %0d expected %0d", tag, done_cycle, 33 + extra); end
    n_cmp++;
    if (busy_first !== 1) begin n_bad++; $display("[TB] FAIL %s busy_first: got %0d expected 1", tag, busy_first); end
    n_cmp++;
    if (done_after !== 1'b0 || busy_after !== 1'b0) begin
      n_bad++; $display("[TB] FAIL %s release: got done=%b busy=%b expected 0/0", tag, done_after, busy_after);
    end
    n_cmp++;
    if (restore_error !== 1'b0) begin n_bad++; $display("[TB] FAIL %s restore_error: got %b expected 0", tag, restore_error); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({rf_wr_en, pc_load, recovery_done, restore_busy, restore_error} !== 5'b0) begin
      n_bad++; $display("[TB] FAIL reset flags: got %b expected 00000",
                        {rf_wr_en, pc_load, recovery_done, restore_busy, restore_error});
    end
    n_cmp++;
    if (rf_wr_addr !== 5'd0 || rf_wr_data !== 32'd0 || pc_load_val !== 32'd0) begin
      n_bad++; $display("[TB] FAIL reset buses: got addr=%0d data=%h pc=%h expected 0", rf_wr_addr, rf_wr_data, pc_load_val);
    end
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
    exp_pc = 32'd0;
  endtask

  task automatic test_default_restore;
    run_restore(0, 0, 0, 1'b0);
    check_full_restore("default", 0);
  endtask

  task automatic test_checkpoint;
    do_commit(32'h0000_0100, 1'b1, 5'd5, 32'hDEAD_BEEF);
    do_commit(32'h0000_0100, 1'b1, 5'd0, 32'h0000_0001);
    exp_rf[5] = 32'hDEAD_BEEF;
    exp_pc = 32'h0000_0104;
    freeze_cpu = 1'b1;
    run_restore(0, 0, 0, 1'b0);
    freeze_cpu = 1'b0;
    check_full_restore("checkpoint", 0);
  endtask

  task automatic test_freeze_drop;
    do_commit(32'h0000_0200, 1'b1, 5'd3, 32'h0000_0033);
    exp_rf[3] = 32'h0000_0033;
    exp_pc = 32'h0000_0204;
    freeze_cpu = 1'b1;
    do_commit(32'h0000_0300, 1'b1, 5'd3, 32'h0000_000A);
    n_cmp++;
    if (restore_busy !== 1'b0 || recovery_done !== 1'b0 || rf_wr_en !== 1'b0) begin
      n_bad++; $display("[TB] FAIL freeze idle: got busy=%b done=%b en=%b expected 0/0/0", restore_busy, recovery_done, rf_wr_en);
    end
    run_restore(0, 0, 0, 1'b1);
    freeze_cpu = 1'b0;
    check_full_restore("freeze", 0);
  endtask

  task automatic test_pc_wrap;
    do_commit(32'hFFFF_FFFC, 1'b0, 5'd9, 32'h1234_5678);
    exp_pc = 32'h0000_0000;
    run_restore(0, 0, 0, 1'b1);
    check_full_restore("wrap", 0);
  endtask

  task automatic test_stall;
    do_commit(32'h0000_1000, 1'b1, 5'd7, 32'h7777_0007);
    exp_rf[7] = 32'h7777_0007;
    exp_pc = 32'h0000_1004;
    run_restore(7, 3, 0, 1'b0);
    check_full_restore("stall", 3);
    n_cmp++;
    if (hold_err !== 0) begin n_bad++; $display("[TB] FAIL stall hold: got hold_err=%0d expected 0", hold_err); end
  endtask

  task automatic test_abort;
    run_restore(0, 0, 10, 1'b0);
    n_cmp++;
    if (pc_cnt !== 0 || done_cycle !== -1) begin
      n_bad++; $display("[TB] FAIL abort outputs: got pc_cnt=%0d done_cycle=%0d expected 0/-1", pc_cnt, done_cycle);
    end
    n_cmp++;
    if (busy_after !== 1'b0 || rf_wr_en !== 1'b0) begin
      n_bad++; $display("[TB] FAIL abort idle: got busy=%b en=%b expected 0/0", busy_after, rf_wr_en);
    end
    run_restore(0, 0, 0, 1'b0);
    n_cmp++;
    if (first_addr !== 1) begin n_bad++; $display("[TB] FAIL abort restart: got first_addr=%0d expected 1", first_addr); end
    check_full_restore("restart", 0);
  endtask

  task automatic test_reset_clears;
    @(negedge clk);
    recover_cpu = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1; recover_cpu = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (rf_wr_en !== 1'b0 || restore_busy !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset mid: got en=%b busy=%b expected 0/0", rf_wr_en, restore_busy);
    end
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
    exp_pc = 32'd0;
    run_restore(0, 0, 0, 1'b0);
    check_full_restore("postreset", 0);
  endtask

  initial begin
    reset = 1'b1; freeze_cpu = 1'b0; recover_cpu = 1'b0; resume_cpu = 1'b0;
    commit_valid = 1'b0; commit_rd_we = 1'b0; commit_pc = '0; commit_rd = '0; commit_rd_data = '0;
    rf_wr_ready = 1'b1;
    test_reset();
    test_default_restore();
    test_checkpoint();
    test_freeze_drop();
    test_pc_wrap();
    test_stall();
    test_abort();
    test_reset_clears();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
